// File: rtl/servisia_gpio_uart_if.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// servisia_gpio_uart_if : GPIO capture inputs and UART/status outputs
// Revision 1.0
// ----------------------------------------------------------------------------
interface servisia_gpio_uart_if #(
    parameter int DEPTH = 16
) ();
    logic [7:0]             gpio_i;
    logic                   en_i;
    logic                   tx_o;
    logic                   busy_o;
    logic                   overflow_o;
    logic [$clog2(DEPTH):0] level_o;

    modport master (
        output gpio_i, en_i,
        input  tx_o, busy_o, overflow_o, level_o
    );

    modport slave (
        input  gpio_i, en_i,
        output tx_o, busy_o, overflow_o, level_o
    );
endinterface
`default_nettype wire

// File: rtl/servisia_gpio_uart.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// servisia_gpio_uart : queues every GPIO byte change and sends it as 8N1 UART
// Revision 1.0
// ----------------------------------------------------------------------------
module servisia_gpio_uart #(
    parameter int CLK_DIV = 868,
    parameter int DEPTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    servisia_gpio_uart_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [7:0]    gpio_q;
    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, level;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, sh_n;
    logic          tx, tx_n;
    logic          overflow;
    logic          push_req, push, pop, full, empty;

    // Full uses the extra pointer bit: same index, opposite wrap phase.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign push_req = bus.en_i && (bus.gpio_i != gpio_q);
    assign push     = push_req && !full;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        sh_n    = shreg;
        tx_n    = tx;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_n    = mem[rd_ptr[AW-1:0]];
                    cnt_n   = CNT_MAX;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    cnt_n   = CNT_MAX;
                    bit_n   = 3'd0;
                    tx_n    = shreg[0];
                    state_n = DATA;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    cnt_n = CNT_MAX;
                    if (bit_idx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        sh_n  = {1'b0, shreg[7:1]};
                        tx_n  = shreg[1];
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            gpio_q   <= 8'h00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
            tx       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state   <= state_n;
            gpio_q  <= bus.gpio_i;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= sh_n;
            tx      <= tx_n;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_req && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push)
            mem[wr_ptr[AW-1:0]] <= bus.gpio_i;
    end

    assign bus.tx_o       = tx;
    assign bus.overflow_o = overflow;
    assign bus.level_o    = level;
    assign bus.busy_o     = (state != IDLE) || !empty;
endmodule
`default_nettype wire

// File: tb/tb_servisia_gpio_uart.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_servisia_gpio_uart : directed bench for servisia_gpio_uart
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_servisia_gpio_uart;
    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    servisia_gpio_uart_if #(.DEPTH(16)) bus_a ();
    servisia_gpio_uart_if #(.DEPTH(4))  bus_b ();

    servisia_gpio_uart #(.CLK_DIV(4), .DEPTH(16)) u_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a.slave)
    );

    servisia_gpio_uart #(.CLK_DIV(100), .DEPTH(4)) u_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic get_tx(input bit sel);
        return sel ? bus_b.tx_o : bus_a.tx_o;
    endfunction

    // Checks one frame; entered with offset k0-1 already elapsed since tx fell.
    task automatic frame(input bit sel, input logic [7:0] b, input int div, input int k0);
        logic exp;
        int   seg;
        for (int k = k0; k < 10 * div; k++) begin
            tick();
            seg = k / div;
            if (seg == 0)      exp = 1'b0;
            else if (seg <= 8) exp = b[seg-1];
            else               exp = 1'b1;
            if (div <= 4 || (k % div) == div / 2)
                chk($sformatf("frame_%02h_k%0d", b, k), {31'd0, get_tx(sel)}, {31'd0, exp});
        end
    endtask

    task automatic wait_fall(input bit sel, input int maxc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (get_tx(sel) !== 1'b0 && n < maxc);
    endtask

    int n;
    int lows;
    logic [7:0] s;

    initial begin
        rst = 1'b1;
        bus_a.gpio_i = 8'h41;
        bus_a.en_i   = 1'b1;
        bus_b.gpio_i = 8'h00;
        bus_b.en_i   = 1'b0;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_tx", {31'd0, bus_a.tx_o}, 32'd1);
            chk("rst_level", {27'd0, bus_a.level_o}, 32'd0);
            chk("rst_busy", {31'd0, bus_a.busy_o}, 32'd0);
            chk("rst_ovf", {31'd0, bus_a.overflow_o}, 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("rst_push_level", {27'd0, bus_a.level_o}, 32'd1);
        chk("rst_push_tx_idle", {31'd0, bus_a.tx_o}, 32'd1);
        tick();
        chk("rst_pop_level", {27'd0, bus_a.level_o}, 32'd0);
        chk("rst_start_tx", {31'd0, bus_a.tx_o}, 32'd0);
        frame(1'b0, 8'h41, 4, 1);
        tick();
        chk("rst_done_busy", {31'd0, bus_a.busy_o}, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("rst_single_push_level", {27'd0, bus_a.level_o}, 32'd0);
        chk("rst_single_push_tx", {31'd0, bus_a.tx_o}, 32'd1);

        // Single byte 'H'
        bus_a.gpio_i = 8'h48;
        tick();
        chk("h_level", {27'd0, bus_a.level_o}, 32'd1);
        chk("h_tx_pre", {31'd0, bus_a.tx_o}, 32'd1);
        tick();
        chk("h_start", {31'd0, bus_a.tx_o}, 32'd0);
        chk("h_busy", {31'd0, bus_a.busy_o}, 32'd1);
        frame(1'b0, 8'h48, 4, 1);
        chk("h_busy_end", {31'd0, bus_a.busy_o}, 32'd1);
        tick();
        chk("h_busy_fall", {31'd0, bus_a.busy_o}, 32'd0);

        // "Hi!\n" on consecutive cycles
        bus_a.en_i   = 1'b0;
        bus_a.gpio_i = 8'h00;
        tick();
        bus_a.en_i   = 1'b1;
        bus_a.gpio_i = 8'h48;
        tick();
        chk("str_lvl0", {27'd0, bus_a.level_o}, 32'd1);
        bus_a.gpio_i = 8'h69;
        tick();
        chk("str_lvl1", {27'd0, bus_a.level_o}, 32'd1);
        chk("str_start", {31'd0, bus_a.tx_o}, 32'd0);
        bus_a.gpio_i = 8'h21;
        tick();
        chk("str_lvl2", {27'd0, bus_a.level_o}, 32'd2);
        bus_a.gpio_i = 8'h0A;
        tick();
        chk("str_lvl3", {27'd0, bus_a.level_o}, 32'd3);
        frame(1'b0, 8'h48, 4, 3);
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       s = 8'h69;
                1:       s = 8'h21;
                default: s = 8'h0A;
            endcase
            wait_fall(1'b0, 60, n);
            chk($sformatf("str_gap_%02h", s), n, 32'd2);
            frame(1'b0, s, 4, 1);
        end
        tick();
        chk("str_busy_end", {31'd0, bus_a.busy_o}, 32'd0);
        chk("str_level_end", {27'd0, bus_a.level_o}, 32'd0);

        // en_i gating
        bus_a.en_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus_a.gpio_i = 8'(i * 17);
            tick();
            chk("gate_level", {27'd0, bus_a.level_o}, 32'd0);
            chk("gate_tx", {31'd0, bus_a.tx_o}, 32'd1);
        end
        bus_a.en_i = 1'b1;
        tick();
        tick();
        chk("gate_en_level", {27'd0, bus_a.level_o}, 32'd0);
        chk("gate_en_busy", {31'd0, bus_a.busy_o}, 32'd0);

        // Overflow on the DEPTH=4, CLK_DIV=100 instance
        bus_b.en_i = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            bus_b.gpio_i = 8'(i);
            tick();
            case (i)
                1:       chk("ovf_lvl", {29'd0, bus_b.level_o}, 32'd1);
                2:       chk("ovf_lvl", {29'd0, bus_b.level_o}, 32'd1);
                3:       chk("ovf_lvl", {29'd0, bus_b.level_o}, 32'd2);
                4:       chk("ovf_lvl", {29'd0, bus_b.level_o}, 32'd3);
                default: chk("ovf_lvl", {29'd0, bus_b.level_o}, 32'd4);
            endcase
            chk($sformatf("ovf_flag_%0d", i), {31'd0, bus_b.overflow_o}, (i >= 6) ? 32'd1 : 32'd0);
            if (i == 2)
                chk("ovf_start", {31'd0, bus_b.tx_o}, 32'd0);
        end
        bus_b.en_i = 1'b0;
        frame(1'b1, 8'h01, 100, 6);
        for (int i = 2; i <= 5; i++) begin
            wait_fall(1'b1, 1200, n);
            chk($sformatf("ovf_gap_%0d", i), n, 32'd2);
            frame(1'b1, 8'(i), 100, 1);
        end
        tick();
        chk("ovf_busy_end", {31'd0, bus_b.busy_o}, 32'd0);
        chk("ovf_sticky", {31'd0, bus_b.overflow_o}, 32'd1);
        lows = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (bus_b.tx_o !== 1'b1) lows++;
        end
        chk("ovf_no_more_frames", lows, 32'd0);

        // Reset mid-frame with two bytes queued
        bus_a.gpio_i = 8'h5A;
        tick();
        bus_a.gpio_i = 8'hA5;
        tick();
        chk("mid_start", {31'd0, bus_a.tx_o}, 32'd0);
        bus_a.gpio_i = 8'h3C;
        tick();
        chk("mid_queued", {27'd0, bus_a.level_o}, 32'd2);
        for (int i = 0; i < 16; i++) tick();
        chk("mid_bit3", {31'd0, bus_a.tx_o}, 32'd1);
        bus_a.en_i = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_tx", {31'd0, bus_a.tx_o}, 32'd1);
        chk("mid_rst_level", {27'd0, bus_a.level_o}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus_a.busy_o}, 32'd0);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus_a.tx_o !== 1'b1) lows++;
        end
        chk("mid_no_frames", lows, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
